// File: rtl/prores_pkg.sv
// Shared constants and the packer state type for the bitstream packer slice.
package prores_pkg;

   localparam int WORD_W       = 32;
   localparam int ACC_W        = 64;
   localparam int MAX_CODE_LEN = 32;
   localparam int LEN_W        = 6;
   localparam int FILL_W       = 7;

   typedef enum logic [1:0] {
      S_RUN       = 2'd0,
      S_DRAIN     = 2'd1,
      S_WAIT_LAST = 2'd2
   } pack_state_e;

endpackage

// File: rtl/bitstream_packer_align.sv
// Masks and saturates a right-justified codeword, then places it MSB-first at
// bit offset pos_i of a 64-bit accumulator image (zeros everywhere else).
module bitpack_align
   import prores_pkg::*;
(
   input  logic [WORD_W-1:0] code_i,
   input  logic [LEN_W-1:0]  length_i,
   input  logic [FILL_W-1:0] pos_i,
   output logic [LEN_W-1:0]  len_o,
   output logic [ACC_W-1:0]  aligned_o
);

   logic [LEN_W-1:0]  len_sat;
   logic [WORD_W:0]   one_shl;
   logic [WORD_W-1:0] mask;
   logic [WORD_W-1:0] left_just;

   always_comb begin
      len_sat   = (length_i > LEN_W'(MAX_CODE_LEN)) ? LEN_W'(MAX_CODE_LEN) : length_i;
      // Low 32 bits of (1 << 32) are zero, so the subtraction yields all ones.
      one_shl   = (WORD_W+1)'(1) << len_sat;
      mask      = one_shl[WORD_W-1:0] - WORD_W'(1);
      left_just = (code_i & mask) << (LEN_W'(WORD_W) - len_sat);
      aligned_o = {left_just, {WORD_W{1'b0}}} >> pos_i;
      len_o     = len_sat;
   end

endmodule

// File: rtl/bitstream_packer.sv
// Packs variable-length codewords into 32-bit MSB-first words, with a flush
// sequence that pads and marks the final word of a slice.
//
// state       | meaning
// ------------+--------------------------------------------------------------
// S_RUN       | accepting codewords, emitting full words as they complete
// S_DRAIN     | flush requested: input closed, emit full then padded word
// S_WAIT_LAST | last word loaded, waiting for its output handshake
module bitstream_packer
   import prores_pkg::*;
#(
   parameter int WORD_COUNT_W = 24
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    in_valid_i,
   output logic                    in_ready_o,
   input  logic [WORD_W-1:0]       in_code_i,
   input  logic [LEN_W-1:0]        in_length_i,
   input  logic                    flush_i,
   output logic                    out_valid_o,
   input  logic                    out_ready_i,
   output logic [WORD_W-1:0]       out_data_o,
   output logic                    out_last_o,
   output logic                    flush_done_o,
   output logic [WORD_COUNT_W-1:0] word_count_o
);

   pack_state_e             state_q, state_d;
   logic [FILL_W-1:0]       fill_q, fill_d;
   logic [ACC_W-1:0]        acc_q, acc_d;
   logic [WORD_W-1:0]       out_data_q, out_data_d;
   logic                    out_valid_q, out_valid_d;
   logic                    out_last_q, out_last_d;
   logic [WORD_COUNT_W-1:0] word_count_q, word_count_d;

   logic                    slot_free;
   logic                    accept;
   logic                    out_hs;
   logic                    load_full;
   logic                    load_part;
   logic                    flush_done;
   logic [FILL_W-1:0]       code_pos;
   logic [LEN_W-1:0]        code_len;
   logic [ACC_W-1:0]        code_aligned;

   always_comb begin
      slot_free  = !out_valid_q || out_ready_i;
      in_ready_o = (fill_q <= FILL_W'(WORD_W)) && (state_q == S_RUN);
      accept     = in_valid_i && in_ready_o;
      out_hs     = out_valid_q && out_ready_i;
      load_full  = (fill_q >= FILL_W'(WORD_W)) && slot_free;
      load_part  = (state_q == S_DRAIN) && (fill_q < FILL_W'(WORD_W))
                   && (fill_q != '0) && slot_free;
      // An accept alongside a full-word load lands just after the shifted-out word.
      code_pos   = load_full ? (fill_q - FILL_W'(WORD_W)) : fill_q;
   end

   bitpack_align u_align (
      .code_i    (in_code_i),
      .length_i  (in_length_i),
      .pos_i     (code_pos),
      .len_o     (code_len),
      .aligned_o (code_aligned)
   );

   always_comb begin
      state_d    = state_q;
      flush_done = 1'b0;
      case (state_q)
         S_RUN: begin
            if (flush_i) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            if ((load_full && (fill_q == FILL_W'(WORD_W))) || load_part) begin
               state_d = S_WAIT_LAST;
            end else if ((fill_q == '0) && slot_free) begin
               state_d    = S_RUN;
               flush_done = 1'b1;
            end
         end
         S_WAIT_LAST: begin
            if (out_hs && out_last_q) begin
               state_d    = S_RUN;
               flush_done = 1'b1;
            end
         end
         default: state_d = S_RUN;
      endcase
   end

   always_comb begin
      acc_d       = acc_q;
      fill_d      = fill_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;

      if (load_full) begin
         acc_d  = acc_q << WORD_W;
         fill_d = fill_q - FILL_W'(WORD_W);
      end else if (load_part) begin
         acc_d  = '0;
         fill_d = '0;
      end

      if (accept) begin
         acc_d  = acc_d | code_aligned;
         fill_d = fill_d + {1'b0, code_len};
      end

      if (load_full || load_part) begin
         out_data_d  = acc_q[ACC_W-1 -: WORD_W];
         out_valid_d = 1'b1;
         out_last_d  = (state_q == S_DRAIN) && (load_part || (fill_q == FILL_W'(WORD_W)));
      end else if (out_ready_i) begin
         out_valid_d = 1'b0;
         out_last_d  = 1'b0;
      end

      word_count_d = flush_done ? '0 : (word_count_q + WORD_COUNT_W'(out_hs));
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= S_RUN;
         fill_q       <= '0;
         acc_q        <= '0;
         out_data_q   <= '0;
         out_valid_q  <= 1'b0;
         out_last_q   <= 1'b0;
         word_count_q <= '0;
      end else begin
         state_q      <= state_d;
         fill_q       <= fill_d;
         acc_q        <= acc_d;
         out_data_q   <= out_data_d;
         out_valid_q  <= out_valid_d;
         out_last_q   <= out_last_d;
         word_count_q <= word_count_d;
      end
   end

   // The count seen during a handshake already includes that word.
   assign word_count_o = word_count_q + WORD_COUNT_W'(out_hs);
   assign out_valid_o  = out_valid_q;
   assign out_data_o   = out_data_q;
   assign out_last_o   = out_last_q;
   assign flush_done_o = flush_done;

endmodule

// File: tb/tb_bitstream_packer.sv
// Scoreboard bench for bitstream_packer: directed codeword sequences queue their
// expected words and flush counts; a negedge monitor pops and compares.
module tb_bitstream_packer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_code = '0;
   logic [5:0]  in_length = '0;
   logic        flush = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_data;
   logic        out_last;
   logic        flush_done;
   logic [23:0] word_count;

   typedef struct packed {
      logic [31:0] data;
      logic        last;
   } word_t;

   word_t exp_q[$];
   int    done_q[$];
   int    pass_cnt  = 0;
   int    total_cnt = 0;

   bitstream_packer #(.WORD_COUNT_W(24)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .in_valid_i   (in_valid),
      .in_ready_o   (in_ready),
      .in_code_i    (in_code),
      .in_length_i  (in_length),
      .flush_i      (flush),
      .out_valid_o  (out_valid),
      .out_ready_i  (out_ready),
      .out_data_o   (out_data),
      .out_last_o   (out_last),
      .flush_done_o (flush_done),
      .word_count_o (word_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   // Monitor: pop expected words on every output handshake, flush counts on FLUSH_DONE.
   word_t mon_w;
   int    mon_d;
   always @(negedge clk) begin
      if (!rst) begin
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               total_cnt++;
               $display("FAIL unexpected_word: got 0x%08h last=%0b expected no word", out_data, out_last);
            end else begin
               mon_w = exp_q.pop_front();
               chk("word_data", out_data, mon_w.data);
               chk("word_last", 32'(out_last), 32'(mon_w.last));
            end
         end
         if (flush_done) begin
            if (done_q.size() == 0) begin
               total_cnt++;
               $display("FAIL unexpected_flush_done: got count %0d expected no pulse", word_count);
            end else begin
               mon_d = done_q.pop_front();
               chk("flush_word_count", 32'(word_count), 32'(mon_d));
            end
         end
      end
   end

   // All tasks are entered 1 time unit after a rising edge.
   task automatic send(input logic [31:0] c, input logic [5:0] l);
      int n = 0;
      in_code   = c;
      in_length = l;
      in_valid  = 1'b1;
      @(negedge clk);
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         total_cnt++;
         $display("FAIL send_timeout: got in_ready=0 expected 1 within 200 cycles");
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic do_flush();
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((exp_q.size() != 0 || done_q.size() != 0) && n < 300) begin
         @(posedge clk);
         n++;
      end
      if (n >= 300) begin
         total_cnt++;
         $display("FAIL idle_timeout: got %0d words %0d flushes pending expected 0", exp_q.size(), done_q.size());
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before 200000");
      $fatal(1);
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", out_data, 32'd0);
      chk("rst_out_last", 32'(out_last), 32'd0);
      chk("rst_flush_done", 32'(flush_done), 32'd0);
      chk("rst_word_count", 32'(word_count), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;

      // Empty flush: done one cycle later, count 0, no word.
      done_q.push_back(0);
      do_flush();
      @(negedge clk);
      chk("empty_flush_done", 32'(flush_done), 32'd1);
      chk("empty_flush_no_word", 32'(out_valid), 32'd0);
      @(negedge clk);
      chk("empty_flush_pulse_end", 32'(flush_done), 32'd0);
      @(posedge clk);
      #1;

      // Eight 4-bit ones: one word, valid two cycles after the 8th accept.
      exp_q.push_back('{32'hFFFF_FFFF, 1'b0});
      for (int i = 0; i < 8; i++) send(32'hF, 6'd4);
      @(negedge clk);
      chk("latency_n1_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      chk("latency_n2_valid", 32'(out_valid), 32'd1);
      @(posedge clk);
      #1;
      wait_idle();
      done_q.push_back(1);
      do_flush();
      wait_idle();

      // Short code then flush: padded single last word.
      exp_q.push_back('{32'hC000_0000, 1'b1});
      done_q.push_back(1);
      send(32'h3, 6'd2);
      do_flush();
      wait_idle();

      // Word straddle, flush in the same cycle as the final accept.
      exp_q.push_back('{32'h0000_0003, 1'b0});
      exp_q.push_back('{32'hC000_0000, 1'b1});
      done_q.push_back(2);
      send(32'h0, 6'd30);
      flush = 1'b1;
      send(32'hF, 6'd4);
      flush = 1'b0;
      wait_idle();

      // Masking of high code bits, zero-length no-op, length saturation.
      exp_q.push_back('{32'h5ABC_DEF1, 1'b0});
      exp_q.push_back('{32'h2000_0000, 1'b1});
      done_q.push_back(2);
      send(32'hFFFF_FFF5, 6'd4);
      send(32'h0000_FFFF, 6'd0);
      send(32'hABCD_EF12, 6'd40);
      do_flush();
      wait_idle();

      // Backpressure: three full words buffered, input stalls, output holds.
      out_ready = 1'b0;
      exp_q.push_back('{32'hAAAA_AAAA, 1'b0});
      exp_q.push_back('{32'h5555_5555, 1'b0});
      exp_q.push_back('{32'h1234_5678, 1'b0});
      send(32'hAAAA_AAAA, 6'd32);
      send(32'h5555_5555, 6'd32);
      send(32'h1234_5678, 6'd32);
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      for (int i = 0; i < 3; i++) begin
         chk("bp_hold_valid", 32'(out_valid), 32'd1);
         chk("bp_hold_data", out_data, 32'hAAAA_AAAA);
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      wait_idle();
      done_q.push_back(3);
      do_flush();
      wait_idle();

      // Reset with buffered bits and a pending word discards everything.
      out_ready = 1'b0;
      send(32'h1234_5678, 6'd32);
      send(32'h000F_FFFF, 6'd20);
      @(negedge clk);
      chk("pre_reset_valid", 32'(out_valid), 32'd1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_out_data", out_data, 32'd0);
      chk("mid_rst_out_last", 32'(out_last), 32'd0);
      chk("mid_rst_word_count", 32'(word_count), 32'd0);
      chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      done_q.push_back(0);
      do_flush();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("post_reset_no_word", 32'(out_valid), 32'd0);
      end
      @(posedge clk);
      #1;
      wait_idle();

      chk("words_outstanding", 32'(exp_q.size()), 32'd0);
      chk("flushes_outstanding", 32'(done_q.size()), 32'd0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
